// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        DONE
    } state_t;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam int TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Control-unit side of the multiply/divide sequencer: requests, MTHI/MTLO and results.
interface muldiv_ctrl_if;

    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        divzero;
    logic        timeout;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, divzero, timeout, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, divzero, timeout, hi, lo
    );

endinterface

// File: rtl/muldiv_watchdog.sv
// Clearable up-counter that flags an engine which has been waited on for TIMEOUT cycles.
module muldiv_watchdog
    import muldiv_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic Reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer for the shared mult/div engines: operand capture, start pulse, stall,
// HI/LO commit, MTHI/MTLO, divide-by-zero and watchdog abort.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic         clk,
    input  logic         Reset,
    muldiv_ctrl_if.slave cu,
    output logic [31:0]  eng_a,
    output logic [31:0]  eng_b,
    output logic         multControl,
    output logic         divControl,
    input  logic         multStop,
    input  logic         divStop,
    input  logic [31:0]  mult_hi,
    input  logic [31:0]  mult_lo,
    input  logic [31:0]  div_hi,
    input  logic [31:0]  div_lo
);

    state_t      state, state_nxt;
    logic        op_q;
    logic        divzero_q;
    logic        timeout_q;
    logic [31:0] hi_q, lo_q;
    logic        req_divzero;
    logic        sel_stop;
    logic        wd_expired;
    logic        mt_allowed;

    assign req_divzero = cu.start && (cu.op == OP_DIV) && (cu.b == '0);
    // Only the launched engine's stop counts; the other one may still hold a stale level.
    assign sel_stop    = (op_q == OP_DIV) ? divStop : multStop;
    assign mt_allowed  = (state == IDLE) || (state == DONE);

    muldiv_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk    (clk),
        .Reset  (Reset),
        .clear  (state == LAUNCH),
        .enable (state == WAIT),
        .expired(wd_expired)
    );

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_nxt   = state;
        multControl = 1'b0;
        divControl  = 1'b0;
        cu.busy     = 1'b0;
        cu.done     = 1'b0;
        cu.divzero  = 1'b0;
        cu.timeout  = 1'b0;
        case (state)
            IDLE: begin
                if (cu.start) state_nxt = req_divzero ? DONE : LAUNCH;
            end
            LAUNCH: begin
                multControl = (op_q == OP_MULT);
                divControl  = (op_q == OP_DIV);
                cu.busy     = 1'b1;
                state_nxt   = WAIT;
            end
            WAIT: begin
                cu.busy = 1'b1;
                if (sel_stop || wd_expired) state_nxt = DONE;
            end
            DONE: begin
                cu.done    = 1'b1;
                cu.divzero = divzero_q;
                cu.timeout = timeout_q;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            op_q      <= OP_MULT;
            eng_a     <= '0;
            eng_b     <= '0;
            divzero_q <= 1'b0;
            timeout_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            if (mt_allowed && cu.hi_we) hi_q <= cu.wdata;
            if (mt_allowed && cu.lo_we) lo_q <= cu.wdata;
            case (state)
                IDLE: begin
                    if (req_divzero) begin
                        divzero_q <= 1'b1;
                    end else if (cu.start) begin
                        op_q  <= cu.op;
                        eng_a <= cu.a;
                        eng_b <= cu.b;
                    end
                end
                WAIT: begin
                    if (sel_stop) begin
                        hi_q <= (op_q == OP_DIV) ? div_hi : mult_hi;
                        lo_q <= (op_q == OP_DIV) ? div_lo : mult_lo;
                    end else if (wd_expired) begin
                        timeout_q <= 1'b1;
                    end
                end
                DONE: begin
                    divzero_q <= 1'b0;
                    timeout_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign cu.hi = hi_q;
    assign cu.lo = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized self-checking bench for muldiv_ctrl with behavioural mult/div engine stubs.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    localparam int TO = 40;

    logic        clk = 1'b0;
    logic        Reset = 1'b0;
    logic [31:0] eng_a, eng_b, mult_hi, mult_lo, div_hi, div_lo;
    logic        multControl, divControl, multStop, divStop;

    always #5 clk = ~clk;

    muldiv_ctrl_if cu();

    muldiv_ctrl #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .Reset      (Reset),
        .cu         (cu),
        .eng_a      (eng_a),
        .eng_b      (eng_b),
        .multControl(multControl),
        .divControl (divControl),
        .multStop   (multStop),
        .divStop    (divStop),
        .mult_hi    (mult_hi),
        .mult_lo    (mult_lo),
        .div_hi     (div_hi),
        .div_lo     (div_lo)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_mult(input logic [31:0] x, input logic [31:0] y);
        longint xs, ys;
        xs = $signed(x);
        ys = $signed(y);
        return xs * ys;
    endfunction

    // {remainder, quotient}, signed, truncating toward zero.
    function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y);
        int xs, ys;
        xs = x;
        ys = y;
        if (ys == 0) return '0;
        return {32'(xs % ys), 32'(xs / ys)};
    endfunction

    // Engine stubs: latency set per operation, stop is a level cleared by the next start.
    int   eng_lat  = 0;
    bit   eng_dead = 1'b0;

    logic [31:0] ma, mb, da, db;
    int          m_cnt, d_cnt;
    bit          m_act, d_act;

    always @(posedge clk or posedge Reset) begin
        if (Reset) begin
            multStop <= 1'b0; m_act <= 1'b0; m_cnt <= 0; mult_hi <= '0; mult_lo <= '0;
        end else if (multControl) begin
            multStop <= 1'b0; m_act <= !eng_dead; m_cnt <= eng_lat; ma <= eng_a; mb <= eng_b;
        end else if (m_act) begin
            if (m_cnt == 0) begin
                m_act <= 1'b0; multStop <= 1'b1; {mult_hi, mult_lo} <= ref_mult(ma, mb);
            end else m_cnt <= m_cnt - 1;
        end
    end

    always @(posedge clk or posedge Reset) begin
        if (Reset) begin
            divStop <= 1'b0; d_act <= 1'b0; d_cnt <= 0; div_hi <= '0; div_lo <= '0;
        end else if (divControl) begin
            divStop <= 1'b0; d_act <= !eng_dead; d_cnt <= eng_lat; da <= eng_a; db <= eng_b;
        end else if (d_act) begin
            if (d_cnt == 0) begin
                d_act <= 1'b0; divStop <= 1'b1; {div_hi, div_lo} <= ref_div(da, db);
            end else d_cnt <= d_cnt - 1;
        end
    end

    logic [31:0] mdl_hi = '0;
    logic [31:0] mdl_lo = '0;

    // Called at a negedge with the DUT idle; returns at the negedge of the first IDLE cycle after DONE.
    task automatic run_op(input logic op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                          input int lat_i, input bit dead_i, input bit mt_start, input bit mt_mid,
                          input string tag);
        bit          dz;
        logic [63:0] r;
        int          n_mc, n_dc, n_busy, n_wait, stop_cyc, done_cyc, launch_cyc;
        logic        dz_seen, to_seen;
        logic [31:0] hi_at, lo_at;
        dz = (op_i == OP_DIV) && (b_i == 0);
        n_mc = 0; n_dc = 0; n_busy = 0; n_wait = 0;
        stop_cyc = -1; done_cyc = -1; launch_cyc = -1;
        dz_seen = 1'b0; to_seen = 1'b0; hi_at = '0; lo_at = '0;
        eng_lat = lat_i;
        eng_dead = dead_i;
        cu.start = 1'b1; cu.op = op_i; cu.a = a_i; cu.b = b_i;
        if (mt_start) begin
            cu.hi_we = 1'b1; cu.lo_we = 1'b1; cu.wdata = $urandom;
            mdl_hi = cu.wdata; mdl_lo = cu.wdata;
        end
        if (!dz && !dead_i) begin
            r = op_i ? ref_div(a_i, b_i) : ref_mult(a_i, b_i);
            mdl_hi = r[63:32];
            mdl_lo = r[31:0];
        end
        for (int k = 1; k <= 200 && done_cyc < 0; k++) begin
            @(negedge clk);
            cu.start = 1'b0; cu.hi_we = 1'b0; cu.lo_we = 1'b0;
            cu.op = 1'($urandom); cu.a = $urandom; cu.b = $urandom;
            if (multControl) n_mc++;
            if (divControl) n_dc++;
            if ((multControl || divControl) && launch_cyc < 0) launch_cyc = k;
            if (cu.busy) n_busy++;
            if (cu.busy && !multControl && !divControl) begin
                n_wait++;
                if (stop_cyc < 0 && (op_i ? divStop : multStop)) stop_cyc = k;
            end
            if (cu.done) begin
                done_cyc = k; dz_seen = cu.divzero; to_seen = cu.timeout;
                hi_at = cu.hi; lo_at = cu.lo;
            end else if (mt_mid && cu.busy && k == 6) begin
                cu.hi_we = 1'b1; cu.lo_we = 1'b1; cu.wdata = 32'hDEADBEEF;
            end
        end
        check({tag, "_done_seen"}, done_cyc > 0, 1'b1);
        check({tag, "_divzero"}, dz_seen, dz);
        check({tag, "_timeout"}, to_seen, dead_i);
        check({tag, "_hi"}, hi_at, mdl_hi);
        check({tag, "_lo"}, lo_at, mdl_lo);
        if (dz) begin
            check({tag, "_dz_done_cycle"}, done_cyc, 1);
            check({tag, "_dz_launches"}, n_mc + n_dc, 0);
            check({tag, "_dz_busy"}, n_busy, 0);
        end else begin
            check({tag, "_mult_pulses"}, n_mc, (op_i == OP_MULT) ? 1 : 0);
            check({tag, "_div_pulses"}, n_dc, (op_i == OP_DIV) ? 1 : 0);
            check({tag, "_launch_cycle"}, launch_cyc, 1);
            check({tag, "_busy_cycles"}, n_busy, done_cyc - 1);
            if (dead_i) check({tag, "_wait_cycles"}, n_wait, TO);
            else        check({tag, "_done_after_stop"}, done_cyc, stop_cyc + 1);
        end
        @(negedge clk);
        check({tag, "_after_done"}, {cu.done, cu.busy, cu.divzero, cu.timeout}, 4'b0000);
    endtask

    int done_cnt;

    initial begin
        cu.start = 1'b0; cu.op = 1'b0; cu.a = '0; cu.b = '0;
        cu.hi_we = 1'b0; cu.lo_we = 1'b0; cu.wdata = '0;

        #1 Reset = 1'b1;
        @(negedge clk);
        check("reset_ctrl", {cu.busy, cu.done, cu.divzero, cu.timeout, multControl, divControl}, '0);
        check("reset_hilo", {cu.hi, cu.lo}, '0);
        check("reset_eng", {eng_a, eng_b}, '0);
        @(negedge clk);
        Reset = 1'b0;
        @(negedge clk);

        // MTHI/MTLO in IDLE
        cu.hi_we = 1'b1; cu.lo_we = 1'b1; cu.wdata = 32'h11111111;
        @(negedge clk);
        cu.hi_we = 1'b0; cu.wdata = 32'h22222222;
        @(negedge clk);
        cu.lo_we = 1'b0;
        mdl_hi = 32'h11111111; mdl_lo = 32'h22222222;
        check("mt_hi", cu.hi, 32'h11111111);
        check("mt_lo", cu.lo, 32'h22222222);

        run_op(OP_DIV, 32'd5, 32'd0, 0, 1'b0, 1'b0, 1'b0, "divzero");
        check("divzero_keep", {cu.hi, cu.lo}, {32'h11111111, 32'h22222222});

        run_op(OP_MULT, 32'd7, 32'hFFFFFFFD, 33, 1'b0, 1'b0, 1'b0, "mult");
        check("mult_const", {cu.hi, cu.lo}, {32'hFFFFFFFF, 32'hFFFFFFEB});

        run_op(OP_DIV, 32'd100, 32'd7, 20, 1'b0, 1'b0, 1'b0, "div");
        check("div_const", {cu.hi, cu.lo}, {32'd2, 32'd14});

        run_op(OP_MULT, 32'd9, 32'd9, 0, 1'b1, 1'b0, 1'b1, "timeout");
        check("timeout_keep", {cu.hi, cu.lo}, {32'd2, 32'd14});
        run_op(OP_MULT, 32'hFFFF0000, 32'h00012345, 5, 1'b0, 1'b0, 1'b0, "post_to");

        cu.hi_we = 1'b1; cu.wdata = 32'hDEADBEEF;
        @(negedge clk);
        cu.hi_we = 1'b0;
        mdl_hi = 32'hDEADBEEF;
        check("mthi_idle", cu.hi, 32'hDEADBEEF);

        for (int i = 0; i < 25; i++) begin
            logic        op_r;
            logic [31:0] a_r, b_r;
            op_r = 1'($urandom);
            a_r  = $urandom;
            b_r  = ($urandom_range(0, 5) == 0) ? 32'd0 :
                   ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 100)) : $urandom;
            if (op_r == OP_DIV && a_r == 32'h80000000 && b_r == 32'hFFFFFFFF) b_r = 32'd1;
            run_op(op_r, a_r, b_r, $urandom_range(0, 33), 1'b0,
                   $urandom_range(0, 3) == 0, 1'b0, $sformatf("rnd%0d", i));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset ten cycles into a MULT
        eng_lat = 30; eng_dead = 1'b0;
        cu.start = 1'b1; cu.op = OP_MULT; cu.a = 32'd5; cu.b = 32'd6;
        @(negedge clk);
        cu.start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_reset_busy", cu.busy, 1'b1);
        #2 Reset = 1'b1;
        #1;
        check("midrst_ctrl", {cu.busy, cu.done, cu.divzero, cu.timeout, multControl, divControl}, '0);
        check("midrst_hilo", {cu.hi, cu.lo}, '0);
        check("midrst_eng", {eng_a, eng_b}, '0);
        mdl_hi = '0; mdl_lo = '0;
        done_cnt = 0;
        @(negedge clk);
        Reset = 1'b0;
        repeat (45) begin
            @(negedge clk);
            if (cu.done) done_cnt++;
        end
        check("midrst_no_done", done_cnt, 0);
        run_op(OP_MULT, 32'd3, 32'd4, 10, 1'b0, 1'b0, 1'b0, "after_rst");
        check("after_rst_const", {cu.hi, cu.lo}, {32'd0, 32'd12});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

endmodule
